// File: rtl/gon_pkg.sv
// Shared types, default sizes and the column-tag match helper for the GON X-bus.
package gon_pkg;

    localparam int DATA_WIDTH    = 64;
    localparam int COL_TAG_WIDTH = 4;
    localparam int NUM_OF_COLS   = 14;

    typedef logic [COL_TAG_WIDTH-1:0] col_tag_t;

    // A column hits when its ID agrees with the tag on every bit the mask selects.
    function automatic logic tag_hit(input col_tag_t id, input col_tag_t tag, input col_tag_t mask);
        return ((id ^ tag) & mask) == {COL_TAG_WIDTH{1'b0}};
    endfunction

endpackage

// File: rtl/gon_col_fifo.sv
// Per-column FIFO with a registered head word and registered valid.
module gon_col_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  full,
    output logic                  valid,
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] data
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_nxt_s;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      count_left_s;
    logic [CNT_W-1:0]      count_nxt_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  valid_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [DATA_WIDTH-1:0] head_nxt_s;

    assign full  = (count_r == DEPTH_C);
    assign valid = valid_r;
    assign data  = data_r;

    // Next occupancy and next head word; an empty-after-pop FIFO takes the pushed word straight into the head.
    always_comb begin
        push_s       = push && (count_r != DEPTH_C);
        pop_s        = valid_r && ready;
        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        count_left_s = pop_s ? (count_r - CNT_W'(1)) : count_r;
        count_nxt_s  = push_s ? (count_left_s + CNT_W'(1)) : count_left_s;
        if (count_left_s == {CNT_W{1'b0}}) begin
            head_nxt_s = push_s ? push_data : data_r;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and the registered head.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            valid_r  <= 1'b0;
            data_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            valid_r  <= (count_nxt_s != {CNT_W{1'b0}});
            data_r   <= head_nxt_s;
        end
    end

endmodule

// File: rtl/gon_xbus_mcast.sv
// Mask-based multicast X-bus: one source beat is copied into every column FIFO whose ID matches.
module gon_xbus_mcast #(
    parameter int DATA_WIDTH    = 64,
    parameter int COL_TAG_WIDTH = 4,
    parameter int NUM_OF_COLS   = 14,
    parameter int FIFO_DEPTH    = 2,
    parameter int MISS_CNT_W    = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [COL_TAG_WIDTH-1:0]         in_tag,
    input  logic [COL_TAG_WIDTH-1:0]         in_mask,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             cfg_we,
    input  logic [$clog2(NUM_OF_COLS)-1:0]   cfg_col,
    input  logic [COL_TAG_WIDTH-1:0]         cfg_id,
    output logic [0:NUM_OF_COLS-1]           col_valid,
    input  logic [0:NUM_OF_COLS-1]           col_ready,
    output logic [DATA_WIDTH-1:0]            col_data [0:NUM_OF_COLS-1],
    output logic [MISS_CNT_W-1:0]            miss_cnt
);
    import gon_pkg::*;

    logic [COL_TAG_WIDTH-1:0] col_id_r [NUM_OF_COLS];
    logic [0:NUM_OF_COLS-1]   hit_s;
    logic [0:NUM_OF_COLS-1]   full_s;
    logic [0:NUM_OF_COLS-1]   push_s;
    logic                     in_ready_s;
    logic                     accept_s;
    logic                     miss_s;
    logic [MISS_CNT_W-1:0]    miss_cnt_r;

    assign in_ready = in_ready_s;
    assign miss_cnt = miss_cnt_r;

    // Hit vector and all-or-nothing admission: a beat waits while any hit column is full.
    always_comb begin
        in_ready_s = 1'b1;
        hit_s      = {NUM_OF_COLS{1'b0}};
        for (int i = 0; i < NUM_OF_COLS; i++) begin
            hit_s[i] = tag_hit(col_id_r[i], in_tag, in_mask);
            if (hit_s[i] && full_s[i]) begin
                in_ready_s = 1'b0;
            end else begin
                in_ready_s = in_ready_s;
            end
        end
        accept_s = in_valid && in_ready_s;
        push_s   = accept_s ? hit_s : {NUM_OF_COLS{1'b0}};
        miss_s   = accept_s && (hit_s == {NUM_OF_COLS{1'b0}});
    end

    // Column ID table; out-of-range writes match no index and are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OF_COLS; i++) begin
                col_id_r[i] <= COL_TAG_WIDTH'(i);
            end
        end else begin
            for (int i = 0; i < NUM_OF_COLS; i++) begin
                if (cfg_we && (int'(cfg_col) == i)) begin
                    col_id_r[i] <= cfg_id;
                end
            end
        end
    end

    // Saturating count of beats that reached no column.
    always_ff @(posedge clk) begin
        if (reset) begin
            miss_cnt_r <= {MISS_CNT_W{1'b0}};
        end else if (miss_s && (miss_cnt_r != {MISS_CNT_W{1'b1}})) begin
            miss_cnt_r <= miss_cnt_r + MISS_CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_OF_COLS; g++) begin : g_col
        gon_col_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push_s[g]),
            .push_data (in_data),
            .full      (full_s[g]),
            .valid     (col_valid[g]),
            .ready     (col_ready[g]),
            .data      (col_data[g])
        );
    end

endmodule

// File: tb/tb_gon_xbus_mcast.sv
// Scoreboard bench for gon_xbus_mcast: directed beats push expectations, a monitor checks every pop.
module tb_gon_xbus_mcast;
    localparam int DW = 64;
    localparam int TW = 4;
    localparam int NC = 14;
    localparam int CW = $clog2(NC);
    localparam int MW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] in_tag;
    logic [TW-1:0] in_mask;
    logic [DW-1:0] in_data;
    logic          cfg_we;
    logic [CW-1:0] cfg_col;
    logic [TW-1:0] cfg_id;
    logic [0:NC-1] col_valid;
    logic [0:NC-1] col_ready;
    logic [DW-1:0] col_data [0:NC-1];
    logic [MW-1:0] miss_cnt;

    int            total = 0;
    int            bad   = 0;
    int            exp_miss;
    logic [DW-1:0] exp_q [NC][$];
    logic [TW-1:0] model_id [NC];
    logic [DW-1:0] mon_exp;

    always #5 clk = ~clk;

    gon_xbus_mcast dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tag    (in_tag),
        .in_mask   (in_mask),
        .in_data   (in_data),
        .cfg_we    (cfg_we),
        .cfg_col   (cfg_col),
        .cfg_id    (cfg_id),
        .col_valid (col_valid),
        .col_ready (col_ready),
        .col_data  (col_data),
        .miss_cnt  (miss_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [0:NC-1] cols(input int lo, input int hi);
        logic [0:NC-1] v;
        v = {NC{1'b0}};
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NC; i++) begin
            model_id[i] = TW'(i);
            exp_q[i].delete();
        end
        exp_miss = 0;
    endtask

    // Present one beat, wait (bounded) for in_ready, record expectations, complete on the next edge.
    task automatic send(input logic [TW-1:0] tag, input logic [TW-1:0] mask, input logic [DW-1:0] data);
        int n;
        bit any;
        in_valid = 1'b1;
        in_tag   = tag;
        in_mask  = mask;
        in_data  = data;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) begin
            check("send_accept", {63'd0, in_ready}, 64'd1);
        end else begin
            any = 1'b0;
            for (int i = 0; i < NC; i++) begin
                if (((model_id[i] ^ tag) & mask) == 4'h0) begin
                    exp_q[i].push_back(data);
                    any = 1'b1;
                end
            end
            if (!any && exp_miss < 65535) exp_miss++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every handshake on a column pops that column's expected queue.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NC; i++) begin
                if (col_valid[i] && col_ready[i]) begin
                    total++;
                    if (exp_q[i].size() == 0) begin
                        bad++;
                        $display("FAIL col%0d_unexpected: got data %0h, expected no beat", i, col_data[i]);
                    end else begin
                        mon_exp = exp_q[i].pop_front();
                        if (col_data[i] !== mon_exp) begin
                            bad++;
                            $display("FAIL col%0d_data: got %0h, expected %0h", i, col_data[i], mon_exp);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int left;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_tag    = 4'h0;
        in_mask   = 4'h0;
        in_data   = 64'h0;
        cfg_we    = 1'b0;
        cfg_col   = 4'd0;
        cfg_id    = 4'h0;
        col_ready = {NC{1'b1}};
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_valid", 64'(col_valid), 64'd0);
        check("reset_miss", 64'(miss_cnt), 64'd0);
        check("reset_ready", {63'd0, in_ready}, 64'd1);
        check("reset_data5", col_data[5], 64'd0);
        @(posedge clk);
        #1;

        // T1: exact match reaches column 5 only, one cycle later
        send(4'd5, 4'hF, 64'hA5);
        @(negedge clk);
        check("t1_valid", 64'(col_valid), 64'(cols(5, 5)));
        check("t1_miss", 64'(miss_cnt), 64'd0);
        @(posedge clk);
        #1;

        // T2: broadcast
        send(4'd9, 4'h0, 64'h1);
        @(negedge clk);
        check("t2_valid", 64'(col_valid), 64'(cols(0, NC - 1)));
        check("t2_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // T3: partial mask selects columns 4..7
        send(4'b0100, 4'b1100, 64'h3C);
        @(negedge clk);
        check("t3_valid", 64'(col_valid), 64'(cols(4, 7)));
        @(posedge clk);
        #1;

        // T4: stalled column 3 blocks its own beats but not others
        col_ready[3] = 1'b0;
        send(4'd3, 4'hF, 64'h31);
        send(4'd3, 4'hF, 64'h32);
        in_valid = 1'b1;
        in_tag   = 4'd3;
        in_mask  = 4'hF;
        in_data  = 64'h33;
        @(negedge clk);
        check("t4_full_stall", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send(4'd9, 4'hF, 64'h90);
        @(negedge clk);
        check("t4_hold_data", col_data[3], 64'h31);
        check("t4_hold_valid", {63'd0, col_valid[3]}, 64'd1);
        @(posedge clk);
        #1;
        col_ready[3] = 1'b1;
        in_valid = 1'b1;
        in_tag   = 4'd3;
        in_data  = 64'h33;
        @(negedge clk);
        check("t4_pop_not_through", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        col_ready[3] = 1'b0;
        send(4'd3, 4'hF, 64'h33);
        col_ready[3] = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // T5: config write in the same cycle as a beat; the beat uses the old ID
        cfg_we  = 1'b1;
        cfg_col = 4'd2;
        cfg_id  = 4'd12;
        send(4'd12, 4'hF, 64'hC0);
        cfg_we = 1'b0;
        model_id[2] = 4'd12;
        check("t5_old_id_miss", 64'(miss_cnt), 64'(exp_miss));
        send(4'd12, 4'hF, 64'hC1);
        @(negedge clk);
        check("t5_new_id_valid", 64'(col_valid), 64'(cols(2, 2) | cols(12, 12)));
        @(posedge clk);
        #1;

        // Miss, idle with a missing tag, and an out-of-range config write
        send(4'd15, 4'hF, 64'hFF);
        in_tag = 4'd15;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("miss_count", 64'(miss_cnt), 64'(exp_miss));
        check("miss_expected_one", 64'(exp_miss), 64'd1);
        @(posedge clk);
        #1;
        cfg_we  = 1'b1;
        cfg_col = 4'd14;
        cfg_id  = 4'd5;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        send(4'd5, 4'hF, 64'h55);
        @(negedge clk);
        check("cfg_oob_ignored", 64'(col_valid), 64'(cols(5, 5)));
        @(posedge clk);
        #1;

        // T6: reset while column 0 is full
        col_ready[0] = 1'b0;
        send(4'd0, 4'hF, 64'hA0);
        send(4'd0, 4'hF, 64'hA1);
        @(negedge clk);
        check("t6_full_before", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        reset_model();
        @(posedge clk);
        #1;
        reset = 1'b0;
        col_ready[0] = 1'b1;
        @(negedge clk);
        check("t6_valid", 64'(col_valid), 64'd0);
        check("t6_ready", {63'd0, in_ready}, 64'd1);
        check("t6_miss", 64'(miss_cnt), 64'd0);
        check("t6_data0", col_data[0], 64'd0);
        @(posedge clk);
        #1;
        send(4'd0, 4'hF, 64'hB0);
        @(negedge clk);
        check("t6_id0", 64'(col_valid), 64'(cols(0, 0)));
        @(posedge clk);
        #1;
        send(4'd2, 4'hF, 64'hB2);
        @(negedge clk);
        check("t6_id2", 64'(col_valid), 64'(cols(2, 2)));
        @(posedge clk);
        #1;

        // Drain: every expected beat must have been delivered
        col_ready = {NC{1'b1}};
        repeat (6) @(posedge clk);
        @(negedge clk);
        left = 0;
        for (int i = 0; i < NC; i++) left += exp_q[i].size();
        check("drain_all", 64'(left), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
